// File: rtl/tape_bit_decoder.sv
// -----------------------------------------------------------------------------
// tape_bit_decoder
//
// Cassette tape input decoder. Measures the falling-edge-to-falling-edge period
// of the comparator signal, classifies each period as a 1 bit (short) or a 0 bit
// (long), and frames bytes: start 0, 8 data bits LSB-first, odd parity, then
// stop 1s.
//
// Optional feature macro: TAPE_DEC_LEADER_EN
//   Defined     - a run of LEADER_MIN consecutive 1 bits in IDLE is required
//                 (synced) before a 0 bit is accepted as a start bit.
//   Not defined - synced is tied high and every 0 bit in IDLE starts a frame.
//
// Parameters
//   THRESH      period (clk cycles) below which a bit is 1, otherwise 0
//   MIN_PERIOD  edges closer than this to the reference edge are ignored
//   TIMEOUT     cycles without an accepted edge before the reference is dropped
//   LEADER_MIN  consecutive 1 bits needed for sync (leader feature only)
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   enable      tape motor on; low holds the decoder idle
//   tape_in     asynchronous comparator output
//   dout        last received byte
//   byte_valid  one-cycle strobe, dout/parity_err valid
//   parity_err  parity check failed (qualified by byte_valid)
//   frame_err   one-cycle strobe: stop bit was 0, or timeout mid-frame
//   busy        frame in progress (DATA/PARITY/STOP)
//   synced      leader seen (tied high without the leader feature)
// -----------------------------------------------------------------------------
module tape_bit_decoder #(
  parameter int unsigned THRESH     = 11974,
  parameter int unsigned MIN_PERIOD = 4000,
  parameter int unsigned TIMEOUT    = 32768,
  parameter int unsigned LEADER_MIN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tape_in,
  output logic [7:0] dout,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic       synced
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic        sync_a;
  logic        s;
  logic        s_prev;
  logic        fall;
  logic [15:0] cnt;
  logic        have_ref;
  logic [31:0] period;
  logic        timeout;
  logic        bit_stb;
  logic        bit_val;
  logic [1:0]  state;
  logic [2:0]  n;
  logic [7:0]  sr;
  logic        acc;
  logic        start_ok;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      sync_a <= tape_in;
      s      <= sync_a;
      s_prev <= s;
    end
  end

  assign fall    = s_prev & ~s;
  // Period includes the edge cycle itself: cnt was cleared on the previous edge.
  assign period  = 32'(cnt) + 32'd1;
  assign timeout = (32'(cnt) == TIMEOUT);
  // An edge coinciding with a timeout only re-establishes the reference.
  assign bit_stb = fall & have_ref & ~timeout & (period >= MIN_PERIOD);
  assign bit_val = (period < THRESH);
  assign busy    = (state != ST_IDLE);

  // Period counter and reference-edge tracking.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt      <= '0;
      have_ref <= 1'b0;
    end else if (fall && (!have_ref || timeout)) begin
      have_ref <= 1'b1;
      cnt      <= '0;
    end else if (timeout) begin
      have_ref <= 1'b0;          // cnt stays saturated at TIMEOUT
    end else if (bit_stb) begin
      cnt      <= '0;
    end else begin
      cnt      <= cnt + 16'd1;   // includes ignored glitch edges
    end
  end

  // Byte framing: one transition per decoded bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      n          <= '0;
      sr         <= '0;
      acc        <= 1'b0;
      dout       <= '0;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
      end else if (timeout) begin
        state     <= ST_IDLE;
        frame_err <= busy;
      end else if (bit_stb) begin
        case (state)
          ST_IDLE: begin
            // 1 bits here are leader or trailing stop bits and are absorbed.
            if (!bit_val && start_ok) begin
              state <= ST_DATA;
              n     <= '0;
              acc   <= 1'b1;     // odd parity: seed accumulator with 1
            end
          end
          ST_DATA: begin
            sr  <= {bit_val, sr[7:1]};
            acc <= acc ^ bit_val;
            n   <= n + 3'd1;
            if (n == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            dout       <= sr;
            parity_err <= (acc != bit_val);
            byte_valid <= 1'b1;
            state      <= ST_STOP;
          end
          ST_STOP: begin
            // A 0 here is a framing error and is not reused as a start bit.
            if (!bit_val) begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TAPE_DEC_LEADER_EN
  logic [7:0] lead_cnt;
  logic [7:0] lead_nxt;

  assign lead_nxt = (lead_cnt == 8'hFF) ? lead_cnt : lead_cnt + 8'd1;

  // Leader detection: counts consecutive 1 bits seen while idle.
  always_ff @(posedge clk) begin
    if (reset || !enable || timeout) begin
      lead_cnt <= '0;
      synced   <= 1'b0;
    end else if (bit_stb && state == ST_IDLE) begin
      if (bit_val) begin
        lead_cnt <= lead_nxt;
        if (32'(lead_nxt) >= LEADER_MIN) begin
          synced <= 1'b1;
        end
      end else begin
        lead_cnt <= '0;
      end
    end
  end

  assign start_ok = synced;
`else
  assign synced   = 1'b1;
  assign start_ok = 1'b1;
`endif

endmodule

// File: tb/tb_tape_bit_decoder.sv
// -----------------------------------------------------------------------------
// tb_tape_bit_decoder
//
// Drives tape waveforms (falling edge at the start of each bit, low phase then
// high phase) with timing scaled down ~100x so runs stay short. A behavioural
// model works on the list of bit periods sent: each period is classified from
// the threshold rules, bits are framed as start/8 data/parity/stop, and the
// expected strobes are queued. A separate monitor pops the queue whenever the
// decoder strobes byte_valid or frame_err.
// Build with +define+TAPE_DEC_LEADER_EN to exercise the leader feature.
// -----------------------------------------------------------------------------
module tb_tape_bit_decoder;

  localparam int unsigned THRESH = 120;
  localparam int unsigned MIN_P  = 40;
  localparam int unsigned TMO    = 400;
  localparam int unsigned LMIN   = 16;
  localparam int P1 = 87;
  localparam int L1 = 44;
  localparam int P0 = 152;
  localparam int L0 = 65;
  localparam int HOLD = 600;
`ifdef TAPE_DEC_LEADER_EN
  localparam bit SYNC_RST = 1'b0;
`else
  localparam bit SYNC_RST = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       tape_in;
  logic [7:0] dout;
  logic       byte_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic       synced;

  tape_bit_decoder #(
    .THRESH    (THRESH),
    .MIN_PERIOD(MIN_P),
    .TIMEOUT   (TMO),
    .LEADER_MIN(LMIN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .tape_in   (tape_in),
    .dout      (dout),
    .byte_valid(byte_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy),
    .synced    (synced)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_byte;
    logic [7:0] data;
    logic       perr;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mev;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  bit          jitter_on = 1'b0;

  // Reference model state
  bit         m_ref;
  bit         m_pend;
  bit         m_pbit;
  bit         m_inframe;
  bit         m_synced;
  int         m_lead;
  bit         m_fbits[$];
  logic [7:0] m_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame_err();
    ev_t e;
    e.is_byte = 1'b0;
    e.data    = '0;
    e.perr    = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic model_bit(input bit b);
    ev_t        e;
    logic [7:0] d;
    int         ones;
    if (!m_inframe) begin
`ifdef TAPE_DEC_LEADER_EN
      if (b) begin
        m_lead++;
        if (m_lead >= int'(LMIN)) m_synced = 1'b1;
      end else begin
        if (m_synced) begin
          m_inframe = 1'b1;
          m_fbits.delete();
        end
        m_lead = 0;
      end
`else
      if (!b) begin
        m_inframe = 1'b1;
        m_fbits.delete();
      end
`endif
    end else begin
      m_fbits.push_back(b);
      if (m_fbits.size() == 9) begin
        for (int i = 0; i < 8; i++) d[i] = m_fbits[i];
        ones      = $countones(d) + int'(m_fbits[8]);
        e.is_byte = 1'b1;
        e.data    = d;
        e.perr    = (ones % 2 == 0);
        exp_q.push_back(e);
        m_dout = d;
      end else if (m_fbits.size() == 10) begin
        if (!b) push_frame_err();
        m_inframe = 1'b0;
      end
    end
  endtask

  task automatic model_abort();
    m_inframe = 1'b0;
    m_ref     = 1'b0;
    m_pend    = 1'b0;
`ifdef TAPE_DEC_LEADER_EN
    m_synced  = 1'b0;
    m_lead    = 0;
`endif
  endtask

  task automatic model_timeout();
    if (m_inframe) push_frame_err();
    model_abort();
  endtask

  // One bit cell of p cycles: low for l cycles, optional high blip [gr,gf).
  task automatic send_bit(input int p, input int l, input int gr, input int gf);
    if (m_ref && m_pend) model_bit(m_pbit);
    m_ref  = 1'b1;
    m_pend = 1'b1;
    m_pbit = (p < int'(THRESH));
    tape_in = 1'b0;
    for (int c = 1; c <= p; c++) begin
      @(posedge clk); #1;
      if (c < p) tape_in = (c >= l) || (gr != 0 && c >= gr && c < gf);
    end
  endtask

  task automatic send_b(input bit b, input bit g);
    int j, gr, gf;
    j  = jitter_on ? int'($urandom_range(16, 0)) - 8 : 0;
    gr = 0;
    gf = 0;
    if (g && b) begin
      gr = 8 + int'($urandom_range(7, 0));
      gf = gr + 5 + int'($urandom_range(10, 0));
    end
    if (b) send_bit(P1 + j, L1, gr, gf);
    else   send_bit(P0 + j, L0, gr, gf);
  endtask

  task automatic send_leader(input int n);
    repeat (n) send_b(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop,
                            input int nstops, input logic [7:0] gmask);
    bit par;
    send_b(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_b(d[i], gmask[i]);
    par = ~(^d);
    if (!par_ok) par = ~par;
    send_b(par, 1'b0);
    send_b(stop, 1'b0);
    repeat (nstops) send_b(1'b1, 1'b0);
  endtask

  task automatic hold_high(input int n);
    model_timeout();
    tape_in = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_status();
    check("busy", busy, m_inframe);
    check("synced", synced, m_synced);
    check("dout_held", dout, m_dout);
  endtask

  always @(negedge clk) begin
    if (byte_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got byte_valid=%0b frame_err=%0b, expected none (t=%0t)",
                 byte_valid, frame_err, $time);
      end else begin
        mev = exp_q.pop_front();
        check("strobe_kind", {30'd0, frame_err, byte_valid}, mev.is_byte ? 32'd1 : 32'd2);
        if (mev.is_byte) begin
          check("dout", dout, mev.data);
          check("parity_err", parity_err, mev.perr);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    int         kind;

    reset     = 1'b1;
    enable    = 1'b1;
    tape_in   = 1'b1;
    m_ref     = 1'b0;
    m_pend    = 1'b0;
    m_inframe = 1'b0;
    m_synced  = SYNC_RST;
    m_lead    = 0;
    m_dout    = '0;

    // 1: reset held 3 cycles with tape_in toggling
    @(posedge clk); #1;
    repeat (3) begin
      tape_in = ~tape_in;
      @(negedge clk);
      check("rst_dout", dout, 8'h00);
      check("rst_byte_valid", byte_valid, 1'b0);
      check("rst_parity_err", parity_err, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_synced", synced, SYNC_RST);
      @(posedge clk); #1;
    end
    tape_in = 1'b1;
    reset   = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_status();

    // 2: leader + 0xA5 good parity + 4 stop bits
    send_leader(20);
    send_frame(8'hA5, 1'b1, 1'b1, 3, 8'h00);
    check_status();
    hold_high(HOLD);

    // 3: 0x01 with wrong parity
    send_leader(20);
    send_frame(8'h01, 1'b0, 1'b1, 3, 8'h00);
    hold_high(HOLD);

    // 4: 0x3C with stop bit 0, then a clean 0x5A
    send_leader(20);
    send_frame(8'h3C, 1'b1, 1'b0, 1, 8'h00);
    check_status();
    send_leader(20);
    send_frame(8'h5A, 1'b1, 1'b1, 2, 8'h00);
    hold_high(HOLD);

    // 5: timeout after 4 data bits, then 0x81 with a short glitch in bit 0
    send_leader(20);
    send_b(1'b0, 1'b0);
    repeat (2) begin
      send_b(1'b1, 1'b0);
      send_b(1'b0, 1'b0);
    end
    check_status();
    hold_high(HOLD);
    check_status();
    send_leader(20);
    send_b(1'b0, 1'b0);
    send_bit(P1, L1, 10, 30);
    for (int i = 1; i < 8; i++) send_b(i == 7, 1'b0);
    send_b(1'b1, 1'b0);
    send_b(1'b1, 1'b0);
    send_b(1'b1, 1'b0);
    hold_high(HOLD);

    // 6: 15 leader bits (too short when sync is required), then 16
    send_leader(15);
    send_frame(8'h42, 1'b1, 1'b1, 2, 8'h00);
    check_status();
    hold_high(HOLD);
    send_leader(16);
    send_frame(8'h42, 1'b1, 1'b1, 2, 8'h00);
    check_status();
    hold_high(HOLD);

    // Period boundaries: THRESH-1, THRESH, MIN_P, and a glitch ending at MIN_P-1
    send_leader(17);
    send_b(1'b0, 1'b0);
    send_bit(int'(THRESH) - 1, 60, 0, 0);
    send_bit(int'(THRESH), 60, 0, 0);
    send_bit(int'(MIN_P), 20, 0, 0);
    send_bit(P1, L1, 20, int'(MIN_P) - 1);
    repeat (4) send_b(1'b0, 1'b0);
    send_b(1'b0, 1'b0);
    send_b(1'b1, 1'b0);
    send_b(1'b1, 1'b0);
    hold_high(HOLD);

    // enable dropped mid-frame: frame discarded, dout held
    send_leader(17);
    send_b(1'b0, 1'b0);
    send_b(1'b1, 1'b0);
    send_b(1'b0, 1'b0);
    check_status();
    enable = 1'b0;
    model_abort();
    repeat (50) begin
      @(posedge clk); #1;
    end
    check_status();
    enable = 1'b1;
    send_leader(17);
    send_frame(8'hC3, 1'b1, 1'b1, 2, 8'h00);
    check_status();

    // reset mid-frame: no strobe, dout back to 0
    send_b(1'b0, 1'b0);
    send_b(1'b1, 1'b0);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    model_abort();
    m_dout   = '0;
    m_synced = SYNC_RST;
    @(posedge clk); #1;
    check_status();

    // Randomized frames with jitter, glitches, bad parity/stop and timeouts
    jitter_on = 1'b1;
    for (int f = 0; f < 6; f++) begin
      d    = 8'($urandom);
      kind = int'($urandom_range(9, 0));
      send_leader(16 + int'($urandom_range(2, 0)));
      if (kind == 0) begin
        send_b(1'b0, 1'b0);
        repeat (int'($urandom_range(7, 1))) send_b(1'($urandom), 1'b0);
        check_status();
        hold_high(HOLD);
      end else begin
        send_frame(d, kind != 1, kind != 2, int'($urandom_range(3, 1)),
                   ($urandom_range(1, 0) == 1) ? 8'($urandom) : 8'h00);
        check_status();
        if ($urandom_range(1, 0) == 1) hold_high(HOLD);
      end
    end
    hold_high(HOLD);
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("pending_expectations", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
